module_arbitro_temporizador: RTL and testbench
==============================================

MODULE_ARBITRO_TEMPORIZADOR -- requirements
Module: module_arbitro_temporizador

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, giving the number of room light FSMs sharing one timer; legal range 2..8.
REQ-002 The block SHALL have port clk_i, input, 1 bit: single system clock (10 MHz domain); all logic rising-edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_i, input, N_REQ bits: per-room timer request level, held by requester until served.
REQ-005 The block SHALL have port gnt_o, output, N_REQ bits: one-hot grant, registered.
REQ-006 The block SHALL have port fin_o, output, N_REQ bits: per-room timeout pulse, registered.
REQ-007 The block SHALL have port tmr_en_o, output, 1 bit: enable to shared timer, registered.
REQ-008 The block SHALL have port tmr_fin_i, input, 1 bit: timer expiry from shared timer.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-011 In IDLE with req_i = 0, the FSM SHALL stay in IDLE; gnt_o = 0 and tmr_en_o = 0.
REQ-012 In IDLE with any req_i bit set, the FSM SHALL select winner w as the first set bit scanning from index ptr upward, wrapping from N_REQ-1 to 0.
REQ-013 On that same edge, the FSM SHALL enter GRANT with gnt_o = one-hot(w) and tmr_en_o = 1, i.e. 1-cycle latency from sampled req to grant.
REQ-014 In GRANT, gnt_o and tmr_en_o SHALL hold constant; req_i changes on bits other than w SHALL be ignored.
REQ-015 In GRANT with tmr_fin_i = 1, the FSM SHALL pulse fin_o[w] high for exactly one cycle on the next edge and enter RELEASE.
REQ-016 In GRANT with req_i[w] = 0 and tmr_fin_i = 0, the FSM SHALL abort to RELEASE without any fin_o pulse.
REQ-017 On simultaneous tmr_fin_i = 1 and req_i[w] = 0, fin SHALL win: fin_o[w] pulses.
REQ-018 In RELEASE, the FSM SHALL hold gnt_o = 0 and tmr_en_o = 0 for exactly one cycle so the timer clears its count, set ptr to (w+1) mod N_REQ, then return to IDLE.
REQ-019 tmr_fin_i SHALL be ignored in IDLE and RELEASE.
REQ-020 Minimum gap from one grant falling to the next grant rising SHALL be 2 cycles (RELEASE + IDLE).
REQ-021 ptr SHALL be $clog2(N_REQ) bits, and its increment SHALL wrap explicitly at N_REQ-1 (non-power-of-2 N_REQ SHALL never yield an illegal index).
REQ-022 gnt_o SHALL never have more than one bit set; fin_o SHALL never have more than one bit set.
REQ-023 A requester still holding req after its fin SHALL re-enter arbitration at lowest priority.

Reset
REQ-024 While rst_i = 0, the block SHALL hold state = IDLE, ptr = 0, gnt_o = 0, fin_o = 0, tmr_en_o = 0, busy_o = 0, asynchronously.
REQ-025 Reset asserted mid-GRANT SHALL drop tmr_en_o immediately with no fin_o pulse.
REQ-026 The first arbitration after rst_i deasserts SHALL occur on the first rising edge.

Structure
REQ-027 The state enum typedef (IDLE, GRANT, RELEASE) and N_REQ default SHALL live in shared package pkg_luces.
REQ-028 Rotating-priority selection SHALL be a combinational sub-module module_prioridad_rr (inputs req, ptr; outputs one-hot winner and valid).
REQ-029 The block SHALL be instantiated in the top between the per-room module_fsm_bombillos instances and the single module_temporizador.

Verification
REQ-030 Bench SHALL cover: reset release, req_i=3'b010 -> gnt_o=3'b010 one edge later; tmr_fin_i pulse -> fin_o=3'b010 one cycle, then RELEASE, ptr=2.
REQ-031 Bench SHALL cover: req_i=3'b111 held, ptr=0 -> grant order 001, 010, 100, 001, each separated by 2 idle cycles.
REQ-032 Bench SHALL cover: GRANT to room 0, then req_i[0] dropped -> RELEASE, fin_o stays 0, tmr_en_o low one cycle.
REQ-033 Bench SHALL cover: tmr_fin_i=1 on the same cycle req_i[w] falls -> fin_o[w] pulses.
REQ-034 Bench SHALL cover: rst_i low mid-GRANT -> gnt_o, tmr_en_o, fin_o all 0 without waiting for a clock edge; next grant after reset from ptr=0.
REQ-035 Bench SHALL cover: N_REQ=5, req only on bit 4 then bit 0 -> ptr wraps 4->0 correctly; gnt_o always one-hot (assertion).

Source files
------------

// File: rtl/pkg_luces.sv
// Shared types and helpers for the room-lighting controllers: FSM state encoding,
// default requester count and small index helpers used by the timer arbiter.
package pkg_luces;

  localparam int N_REQ_DEF = 3;
  localparam int N_REQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } t_estado;

  // One-hot (up to 8 bits) to binary index; returns 0 for an all-zero vector.
  function automatic logic [2:0] f_onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < N_REQ_MAX; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Wraps explicitly at n-1 so a non-power-of-two count never yields an illegal index.
  function automatic logic [2:0] f_ptr_inc(input logic [2:0] p, input int n);
    if (int'(p) >= n - 1) return 3'd0;
    return p + 3'd1;
  endfunction

endpackage

// File: rtl/module_prioridad_rr.sv
// Combinational rotating-priority selector: first set request at or after i_ptr,
// wrapping from N-1 back to 0.
module module_prioridad_rr #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_winner,
  output logic          o_valid
);

  localparam logic [PW:0] N_W = (PW + 1)'(N);

  logic [PW:0] w_idx;

  // One extra bit on the sum keeps ptr+k from overflowing before the wrap.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, i_ptr} + (PW + 1)'(k);
      if (w_idx >= N_W) w_idx = w_idx - N_W;
      if (!o_valid && i_req[w_idx[PW-1:0]]) begin
        o_valid                  = 1'b1;
        o_winner[w_idx[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/module_arbitro_temporizador.sv
// Arbiter granting one shared timer to N_REQ room light FSMs with rotating priority;
// relays the timer expiry back to the granted room as a one-cycle fin pulse.
//
// state   | meaning
// IDLE    | no grant; arbitrate any pending request on the next edge
// GRANT   | timer owned by r_win; wait for expiry or request withdrawal
// RELEASE | one cycle with timer disabled so it clears; advance ptr past r_win
module module_arbitro_temporizador
  import pkg_luces::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [N_REQ-1:0] fin_o,
  output logic             tmr_en_o,
  input  logic             tmr_fin_i,
  output logic             busy_o
);

  localparam int PTR_W = $clog2(N_REQ);

  t_estado              r_state;
  t_estado              w_state_next;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_win;
  logic [N_REQ-1:0]     r_gnt;
  logic [N_REQ-1:0]     r_fin;
  logic                 r_tmr_en;

  logic [PTR_W-1:0]     w_ptr_next;
  logic [PTR_W-1:0]     w_win_next;
  logic [N_REQ-1:0]     w_gnt_next;
  logic [N_REQ-1:0]     w_fin_next;
  logic                 w_tmr_en_next;

  logic [N_REQ-1:0]     w_winner;
  logic                 w_valid;
  logic                 w_req_w;
  logic [2:0]           w_winner_idx;
  logic [2:0]           w_ptr_inc;

  module_prioridad_rr #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_prioridad_rr (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_winner_idx = f_onehot_idx(8'(w_winner));
  assign w_ptr_inc    = f_ptr_inc(3'(r_win), N_REQ);
  assign w_req_w      = req_i[r_win];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_state_next = GRANT;
      GRANT:   if (tmr_fin_i || !w_req_w) w_state_next = RELEASE;
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs; fin takes priority over a withdrawn request.
  always_comb begin
    w_gnt_next    = r_gnt;
    w_tmr_en_next = r_tmr_en;
    w_fin_next    = '0;
    w_ptr_next    = r_ptr;
    w_win_next    = r_win;
    case (r_state)
      IDLE: begin
        w_gnt_next    = w_valid ? w_winner : '0;
        w_tmr_en_next = w_valid;
        if (w_valid) w_win_next = w_winner_idx[PTR_W-1:0];
      end
      GRANT: begin
        if (tmr_fin_i) begin
          w_fin_next    = r_gnt;
          w_gnt_next    = '0;
          w_tmr_en_next = 1'b0;
        end else if (!w_req_w) begin
          w_gnt_next    = '0;
          w_tmr_en_next = 1'b0;
        end
      end
      RELEASE: begin
        w_gnt_next    = '0;
        w_tmr_en_next = 1'b0;
        w_ptr_next    = w_ptr_inc[PTR_W-1:0];
      end
      default: begin
        w_gnt_next    = '0;
        w_tmr_en_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_gnt    <= '0;
      r_fin    <= '0;
      r_tmr_en <= 1'b0;
      r_ptr    <= '0;
      r_win    <= '0;
    end else begin
      r_gnt    <= w_gnt_next;
      r_fin    <= w_fin_next;
      r_tmr_en <= w_tmr_en_next;
      r_ptr    <= w_ptr_next;
      r_win    <= w_win_next;
    end
  end

  assign gnt_o    = r_gnt;
  assign fin_o    = r_fin;
  assign tmr_en_o = r_tmr_en;
  assign busy_o   = (r_state != IDLE);

endmodule

// File: tb/tb_module_arbitro_temporizador.sv
// Directed bench for the timer arbiter: a 3-requester instance for the main
// scenarios and a 5-requester instance for pointer wrap on a non-power-of-two count.
module tb_module_arbitro_temporizador;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst3, tf3, en3, busy3;
  logic [2:0] req3, gnt3, fin3;
  logic       rst5, tf5, en5, busy5;
  logic [4:0] req5, gnt5, fin5;

  int checks = 0;
  int errors = 0;

  module_arbitro_temporizador #(.N_REQ(3)) dut3 (
    .clk_i     (clk),
    .rst_i     (rst3),
    .req_i     (req3),
    .gnt_o     (gnt3),
    .fin_o     (fin3),
    .tmr_en_o  (en3),
    .tmr_fin_i (tf3),
    .busy_o    (busy3)
  );

  module_arbitro_temporizador #(.N_REQ(5)) dut5 (
    .clk_i     (clk),
    .rst_i     (rst5),
    .req_i     (req5),
    .gnt_o     (gnt5),
    .fin_o     (fin5),
    .tmr_en_o  (en5),
    .tmr_fin_i (tf5),
    .busy_o    (busy5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Grant and fin must never carry more than one bit, on either instance.
  always @(negedge clk) begin
    checks++;
    assert ($onehot0(gnt3) && $onehot0(fin3) && $onehot0(gnt5) && $onehot0(fin5)) else begin
      errors++;
      $error("FAIL onehot gnt3=%b fin3=%b gnt5=%b fin5=%b", gnt3, fin3, gnt5, fin5);
    end
  end

  logic [2:0] rr_order [3];

  initial begin
    rr_order = '{3'b001, 3'b010, 3'b100};
    req3 = '0; tf3 = 1'b0; req5 = '0; tf5 = 1'b0;
    rst3 = 1'b1; rst5 = 1'b1;
    #1 rst3 = 1'b0; rst5 = 1'b0;
    #1;
    chk("rst_gnt",  32'(gnt3),  32'h0);
    chk("rst_fin",  32'(fin3),  32'h0);
    chk("rst_en",   32'(en3),   32'h0);
    chk("rst_busy", 32'(busy3), 32'h0);
    chk("rst_ptr",  32'(dut3.r_ptr), 32'h0);

    // Release reset with a request already present: grant on the first edge.
    step();
    rst3 = 1'b1; req3 = 3'b010;
    step();
    chk("first_gnt",  32'(gnt3),  32'h2);
    chk("first_en",   32'(en3),   32'h1);
    chk("first_busy", 32'(busy3), 32'h1);
    req3 = 3'b111;
    step();
    chk("hold_gnt", 32'(gnt3), 32'h2);
    chk("hold_en",  32'(en3),  32'h1);
    tf3 = 1'b1;
    step();
    chk("fin1_fin",  32'(fin3),  32'h2);
    chk("fin1_gnt",  32'(gnt3),  32'h0);
    chk("fin1_en",   32'(en3),   32'h0);
    chk("fin1_busy", 32'(busy3), 32'h1);
    tf3 = 1'b0; req3 = 3'b000;
    step();
    chk("fin1_pulse", 32'(fin3),  32'h0);
    chk("fin1_idle",  32'(busy3), 32'h0);
    chk("fin1_ptr",   32'(dut3.r_ptr), 32'h2);

    // Asynchronous reset in the middle of a grant.
    req3 = 3'b001;
    step();
    chk("pre_rst_gnt", 32'(gnt3), 32'h1);
    #2 rst3 = 1'b0;
    #1;
    chk("mid_rst_gnt",  32'(gnt3),  32'h0);
    chk("mid_rst_en",   32'(en3),   32'h0);
    chk("mid_rst_fin",  32'(fin3),  32'h0);
    chk("mid_rst_busy", 32'(busy3), 32'h0);
    chk("mid_rst_ptr",  32'(dut3.r_ptr), 32'h0);
    step();
    rst3 = 1'b1; req3 = 3'b111;

    // All three held: rotation 001, 010, 100, 001 with a two-cycle gap.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_gnt", 32'(gnt3), 32'(rr_order[i]));
      chk("rr_en",  32'(en3),  32'h1);
      tf3 = 1'b1;
      step();
      chk("rr_fin",      32'(fin3), 32'(rr_order[i]));
      chk("rr_gap1_gnt", 32'(gnt3), 32'h0);
      tf3 = 1'b0;
      step();
      chk("rr_gap2_gnt", 32'(gnt3), 32'h0);
      chk("rr_gap2_fin", 32'(fin3), 32'h0);
    end
    step();
    chk("rr_wrap_gnt", 32'(gnt3), 32'h1);

    // Room 0 withdraws its request: abort without a fin pulse.
    req3 = 3'b110;
    step();
    chk("abort_gnt",  32'(gnt3),  32'h0);
    chk("abort_fin",  32'(fin3),  32'h0);
    chk("abort_en",   32'(en3),   32'h0);
    chk("abort_busy", 32'(busy3), 32'h1);
    step();
    chk("abort_idle_fin",  32'(fin3),  32'h0);
    chk("abort_idle_busy", 32'(busy3), 32'h0);
    chk("abort_ptr",       32'(dut3.r_ptr), 32'h1);
    step();
    chk("after_abort_gnt", 32'(gnt3), 32'h2);
    chk("after_abort_en",  32'(en3),  32'h1);

    // Expiry and withdrawal on the same cycle: fin wins.
    tf3 = 1'b1; req3 = 3'b100;
    step();
    chk("race_fin", 32'(fin3), 32'h2);
    chk("race_gnt", 32'(gnt3), 32'h0);
    req3 = 3'b000;
    step();
    chk("race_fin_off", 32'(fin3),  32'h0);
    chk("race_idle",    32'(busy3), 32'h0);
    step();
    chk("idle_tf_fin", 32'(fin3), 32'h0);
    chk("idle_tf_gnt", 32'(gnt3), 32'h0);
    chk("idle_tf_en",  32'(en3),  32'h0);
    tf3 = 1'b0;

    // Five requesters: pointer wraps from 4 back to 0.
    rst5 = 1'b1; req5 = 5'b10000;
    step();
    chk("n5_gnt4", 32'(gnt5), 32'h10);
    tf5 = 1'b1;
    step();
    chk("n5_fin4", 32'(fin5), 32'h10);
    chk("n5_rel_gnt", 32'(gnt5), 32'h0);
    tf5 = 1'b0; req5 = 5'b00000;
    step();
    chk("n5_ptr_wrap", 32'(dut5.r_ptr), 32'h0);
    chk("n5_idle",     32'(busy5), 32'h0);
    req5 = 5'b01001;
    step();
    chk("n5_gnt0", 32'(gnt5), 32'h01);
    tf5 = 1'b1;
    step();
    chk("n5_fin0", 32'(fin5), 32'h01);
    tf5 = 1'b0;
    step();
    chk("n5_ptr1", 32'(dut5.r_ptr), 32'h1);
    step();
    chk("n5_gnt3", 32'(gnt5), 32'h08);
    chk("n5_en",   32'(en5),  32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
